// File: rtl/player_b_key_decoder.sv
// Purpose : turns PS/2 scan-code bytes into held-key levels (left/right/jump/swing) for player B.
// Latency : outputs registered; they change one cycle after the strobe of the final key-code byte.
// Backpressure: none, every byte is consumed on its strobe. clear drops a byte in the same cycle.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   rx_valid, rx_data     one-cycle byte strobe and the scan-code byte
//   rx_error              one-cycle strobe, the current byte is corrupt (parity/framing)
//   clear                 synchronous release of all keys and FSM to IDLE
//   move_left/move_right  arbitrated direction levels, never both high
//   jump, swing           held-key levels
//   swing_pulse           one-cycle pulse on the swing press edge
module player_b_key_decoder #(
    parameter logic [7:0] KEY_LEFT       = 8'h6B,
    parameter logic [7:0] KEY_RIGHT      = 8'h74,
    parameter logic [7:0] KEY_JUMP       = 8'h75,
    parameter logic [7:0] KEY_SWING      = 8'h72,
    parameter int         PREFIX_TIMEOUT = 20000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       rx_error,
    input  logic       clear,
    output logic       move_left,
    output logic       move_right,
    output logic       jump,
    output logic       swing,
    output logic       swing_pulse
);

    localparam int TW = $clog2(PREFIX_TIMEOUT) + 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(PREFIX_TIMEOUT - 1);

    localparam logic [7:0] BYTE_EXT = 8'hE0;
    localparam logic [7:0] BYTE_BRK = 8'hF0;

    // Bit positions inside the held-key vector.
    localparam int K_LEFT  = 0;
    localparam int K_RIGHT = 1;
    localparam int K_JUMP  = 2;
    localparam int K_SWING = 3;

    typedef enum logic [1:0] {IDLE, EXT, EXT_BRK, BRK} state_t;
    typedef enum logic {DIR_LEFT, DIR_RIGHT} dir_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [3:0]      held_q, held_d;
    dir_t            last_dir_q, last_dir_d;
    logic            move_left_q, move_left_d;
    logic            move_right_q, move_right_d;
    logic            jump_q, swing_q, swing_pulse_q, swing_pulse_d;
    logic [3:0]      key_hit;

    // One-hot match of the current byte against the four player-B keys.
    assign key_hit = {rx_data == KEY_SWING, rx_data == KEY_JUMP,
                      rx_data == KEY_RIGHT, rx_data == KEY_LEFT};

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        held_d     = held_q;
        last_dir_d = last_dir_q;

        if (clear) begin
            state_d = IDLE;
            timer_d = '0;
            held_d  = '0;
        end else if (rx_error) begin
            // A corrupt byte aborts any pending prefix but never touches held keys.
            state_d = IDLE;
            timer_d = '0;
        end else if (rx_valid) begin
            timer_d = '0;
            unique case (state_q)
                IDLE: begin
                    if (rx_data == BYTE_EXT)      state_d = EXT;
                    else if (rx_data == BYTE_BRK) state_d = BRK;
                end
                EXT: begin
                    if (rx_data == BYTE_BRK) begin
                        state_d = EXT_BRK;
                    end else if (rx_data != BYTE_EXT) begin
                        // A make of an already-held key (auto-repeat) leaves last_dir alone.
                        held_d = held_q | key_hit;
                        if (key_hit[K_LEFT] && !held_q[K_LEFT])   last_dir_d = DIR_LEFT;
                        if (key_hit[K_RIGHT] && !held_q[K_RIGHT]) last_dir_d = DIR_RIGHT;
                        state_d = IDLE;
                    end
                end
                EXT_BRK: begin
                    held_d  = held_q & ~key_hit;
                    state_d = IDLE;
                end
                BRK:     state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE) begin
            // Stalled prefix: abandon it after PREFIX_TIMEOUT quiet cycles.
            if (timer_q == TIMER_LAST) state_d = IDLE;
            else                       timer_d = timer_q + TW'(1);
        end

        move_left_d   = held_d[K_LEFT]  & (~held_d[K_RIGHT] | (last_dir_d == DIR_LEFT));
        move_right_d  = held_d[K_RIGHT] & (~held_d[K_LEFT]  | (last_dir_d == DIR_RIGHT));
        swing_pulse_d = held_d[K_SWING] & ~held_q[K_SWING];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            timer_q       <= '0;
            held_q        <= '0;
            last_dir_q    <= DIR_LEFT;
            move_left_q   <= 1'b0;
            move_right_q  <= 1'b0;
            jump_q        <= 1'b0;
            swing_q       <= 1'b0;
            swing_pulse_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            held_q        <= held_d;
            last_dir_q    <= last_dir_d;
            move_left_q   <= move_left_d;
            move_right_q  <= move_right_d;
            jump_q        <= held_d[K_JUMP];
            swing_q       <= held_d[K_SWING];
            swing_pulse_q <= swing_pulse_d;
        end
    end

    assign move_left   = move_left_q;
    assign move_right  = move_right_q;
    assign jump        = jump_q;
    assign swing       = swing_q;
    assign swing_pulse = swing_pulse_q;

endmodule

// File: tb/tb_player_b_key_decoder.sv
// Purpose : directed plus randomized bench for player_b_key_decoder against a byte-level reference model.
// Latency : model predicts outputs for the cycle after each clock edge; checked 1 time unit after the edge.
// Backpressure: none; inputs driven every cycle from a single initial block.
module tb_player_b_key_decoder;

    localparam int TO = 40;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_valid, rx_error, clear;
    logic [7:0] rx_data;
    logic       move_left, move_right, jump, swing, swing_pulse;

    int n_tests = 0;
    int n_fail  = 0;

    player_b_key_decoder #(.PREFIX_TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_error   (rx_error),
        .clear      (clear),
        .move_left  (move_left),
        .move_right (move_right),
        .jump       (jump),
        .swing      (swing),
        .swing_pulse(swing_pulse)
    );

    always #5 clk = ~clk;

    // Reference model: which prefixes are pending, when the last byte came, which keys are down.
    bit m_held[4];      // 0 left, 1 right, 2 jump, 3 swing
    bit m_last_right;   // most recent fresh direction press was right
    bit m_pending, m_ext, m_brk;
    bit m_pulse;
    int m_last_byte_cyc;
    int cyc = 0;

    function automatic int key_index(input logic [7:0] b);
        case (b)
            8'h6B:   return 0;
            8'h74:   return 1;
            8'h75:   return 2;
            8'h72:   return 3;
            default: return -1;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_held[i] = 1'b0;
        m_last_right = 1'b0;
        m_pending = 1'b0; m_ext = 1'b0; m_brk = 1'b0;
        m_pulse = 1'b0;
    endtask

    task automatic model_update(input logic v, input logic [7:0] d, input logic e, input logic c);
        int k;
        m_pulse = 1'b0;
        k = key_index(d);
        if (c) begin
            for (int i = 0; i < 4; i++) m_held[i] = 1'b0;
            m_pending = 1'b0;
        end else if (e) begin
            m_pending = 1'b0;
        end else if (v) begin
            m_last_byte_cyc = cyc;
            if (!m_pending) begin
                if (d == 8'hE0)      begin m_pending = 1; m_ext = 1; m_brk = 0; end
                else if (d == 8'hF0) begin m_pending = 1; m_ext = 0; m_brk = 1; end
            end else if (!m_ext) begin
                m_pending = 1'b0;                       // plain release: not ours
            end else if (!m_brk) begin
                if (d == 8'hF0) m_brk = 1'b1;
                else if (d != 8'hE0) begin
                    if (k >= 0 && !m_held[k]) begin
                        m_held[k] = 1'b1;
                        if (k == 0) m_last_right = 1'b0;
                        if (k == 1) m_last_right = 1'b1;
                        if (k == 3) m_pulse = 1'b1;
                    end
                    m_pending = 1'b0;
                end
            end else begin
                if (k >= 0) m_held[k] = 1'b0;
                m_pending = 1'b0;
            end
        end else if (m_pending && (cyc - m_last_byte_cyc >= TO)) begin
            m_pending = 1'b0;
        end
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_all();
        logic el, er;
        el = m_held[0] & (~m_held[1] | ~m_last_right);
        er = m_held[1] & (~m_held[0] | m_last_right);
        chk("move_left",   move_left,   el);
        chk("move_right",  move_right,  er);
        chk("jump",        jump,        m_held[2]);
        chk("swing",       swing,       m_held[3]);
        chk("swing_pulse", swing_pulse, m_pulse);
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic e, input logic c);
        rx_valid = v; rx_data = d; rx_error = e; clear = c;
        @(posedge clk);
        cyc++;
        model_update(v, d, e, c);
        #1;
        rx_valid = 1'b0; rx_error = 1'b0; clear = 1'b0;
        check_all();
    endtask

    task automatic send(input logic [7:0] d);
        step(1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    int pulses;
    logic [7:0] pool [8] = '{8'hE0, 8'hF0, 8'h6B, 8'h74, 8'h75, 8'h72, 8'h1C, 8'h12};

    initial begin
        rst_n = 1'b0; rx_valid = 1'b0; rx_error = 1'b0; clear = 1'b0; rx_data = 8'h00;
        model_reset();
        #12;
        check_all();                                  // outputs during reset
        @(negedge clk); rst_n = 1'b1;
        idle(2);

        // 1: press and release left
        send(8'hE0); send(8'h6B);
        chk("t1_press_left", move_left, 1'b1);
        send(8'hE0); send(8'hF0); send(8'h6B);
        chk("t1_release_left", move_left, 1'b0);

        // 2: left/right arbitration and auto-repeat of the losing key
        send(8'hE0); send(8'h6B);
        send(8'hE0); send(8'h74);
        chk("t2_right_wins", move_right, 1'b1);
        chk("t2_left_loses", move_left, 1'b0);
        send(8'hE0); send(8'hF0); send(8'h74);
        chk("t2_left_back", move_left, 1'b1);
        send(8'hE0); send(8'h74);
        for (int i = 0; i < 3; i++) begin send(8'hE0); send(8'h6B); end
        chk("t2_repeat_left_stays_off", move_left, 1'b0);
        send(8'hE0); send(8'hF0); send(8'h74);
        send(8'hE0); send(8'hF0); send(8'h6B);

        // 3: swing auto-repeat gives a single pulse
        pulses = 0;
        send(8'hE0); send(8'h72);
        if (swing_pulse) pulses++;
        for (int i = 0; i < 4; i++) begin
            send(8'hE0); if (swing_pulse) pulses++;
            send(8'h72); if (swing_pulse) pulses++;
            chk("t3_swing_held", swing, 1'b1);
        end
        send(8'hE0); send(8'hF0); send(8'h72);
        n_tests++;
        assert (pulses == 1) else begin
            n_fail++;
            $error("FAIL t3_pulse_count observed=%0d expected=1", pulses);
        end
        chk("t3_swing_released", swing, 1'b0);

        // 4: prefix timeout boundary
        send(8'hE0); idle(TO); send(8'h6B);
        chk("t4_timeout_drop", move_left, 1'b0);
        send(8'hE0); idle(TO - 1); send(8'h6B);
        chk("t4_just_in_time", move_left, 1'b1);
        send(8'hF0); send(8'h1C);
        send(8'hE0); send(8'hF0); idle(TO); send(8'h6B);
        chk("t4_break_timeout", move_left, 1'b1);
        send(8'hE0); send(8'hF0); send(8'h6B);

        // 5: rx_error aborts a pending release
        send(8'hE0); send(8'h75);
        send(8'hE0); send(8'hF0);
        step(1'b1, 8'h75, 1'b1, 1'b0);
        chk("t5_error_keeps_jump", jump, 1'b1);
        send(8'h75);                                   // lands in IDLE, ignored
        chk("t5_idle_after_error", jump, 1'b1);
        send(8'hE0); send(8'hF0); send(8'h75);
        chk("t5_jump_released", jump, 1'b0);

        // 6: clear beats a same-cycle byte; async reset mid-sequence
        send(8'hE0); send(8'h6B); send(8'hE0); send(8'h75);
        step(1'b1, 8'hE0, 1'b0, 1'b1);
        chk("t6_clear_left", move_left, 1'b0);
        chk("t6_clear_jump", jump, 1'b0);
        send(8'h6B);                                   // FSM is IDLE so this is ignored
        chk("t6_idle_after_clear", move_left, 1'b0);
        send(8'hE0); send(8'h74); send(8'hE0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk); rst_n = 1'b1;
        send(8'h74);                                   // prefix was wiped by reset
        chk("t6_after_reset", move_right, 1'b0);

        // Randomized traffic with occasional quiet gaps long enough to time out prefixes.
        for (int n = 0; n < 3000; n++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 45)
                step(1'b1, pool[$urandom_range(0, 7)], 1'b0, 1'b0);
            else if (r < 47)
                step($urandom_range(0, 1) == 1, pool[$urandom_range(0, 7)], 1'b1, 1'b0);
            else if (r < 48)
                step($urandom_range(0, 1) == 1, pool[$urandom_range(0, 7)], 1'b0, 1'b1);
            else if (r < 49)
                idle($urandom_range(TO - 3, TO + 3));
            else
                step(1'b0, 8'h00, 1'b0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
